// File: rtl/memwb_pkg.sv
// memwb_pkg: shared types and default widths for the MEM->WB skid stage.
//   - memwb_state_e   : skid controller states (EMPTY / BUSY / FULL)
//   - DATA_W, CTRL_W, RN_W : default payload field widths
//   - WB_WE_BIT       : bit of the write-back control field that enables the register write
//   - memwb_payload_t : packed payload for the default widths
package memwb_pkg;

    localparam int DATA_W    = 32;
    localparam int CTRL_W    = 2;
    localparam int RN_W      = 5;
    localparam int WB_WE_BIT = 0;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } memwb_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] mem_rd;
        logic [DATA_W-1:0] alu;
        logic [CTRL_W-1:0] wb;
        logic [RN_W-1:0]   wn;
    } memwb_payload_t;

endpackage

// File: rtl/memwb_skid_ctrl.sv
// memwb_skid_ctrl: occupancy state machine of the two-entry MEM->WB skid buffer.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   flush           : drop every held entry (next state EMPTY)
//   in_valid        : upstream presents an entry
//   out_ready       : downstream consumes the presented entry
//   in_ready        : registered, high unless FULL (no path from out_ready)
//   out_valid       : registered, high unless EMPTY
//   full            : registered, high while FULL
//   load_main       : main payload register loads this cycle
//   load_skid       : skid payload register loads this cycle
//   sel_skid        : main loads from skid instead of from the input
module memwb_skid_ctrl (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic in_valid,
    input  logic out_ready,
    output logic in_ready,
    output logic out_valid,
    output logic full,
    output logic load_main,
    output logic load_skid,
    output logic sel_skid
);
    import memwb_pkg::*;

    memwb_state_e state_r;
    memwb_state_e state_nxt_s;
    logic         in_ready_r;
    logic         out_valid_r;
    logic         full_r;
    logic         in_fire_s;
    logic         out_fire_s;
    logic         load_main_s;
    logic         load_skid_s;
    logic         sel_skid_s;

    assign in_fire_s  = in_valid & in_ready_r;
    assign out_fire_s = out_valid_r & out_ready;

    // Next-state and payload-load decode.
    always_comb begin
        state_nxt_s = state_r;
        load_main_s = 1'b0;
        load_skid_s = 1'b0;
        sel_skid_s  = 1'b0;
        if (rst || flush) begin
            state_nxt_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (in_fire_s) begin
                        load_main_s = 1'b1;
                        state_nxt_s = BUSY;
                    end else begin
                        state_nxt_s = EMPTY;
                    end
                end
                BUSY: begin
                    if (in_fire_s && out_fire_s) begin
                        load_main_s = 1'b1;
                        state_nxt_s = BUSY;
                    end else if (in_fire_s) begin
                        // Backpressure just appeared: the accepted entry parks in skid.
                        load_skid_s = 1'b1;
                        state_nxt_s = FULL;
                    end else if (out_fire_s) begin
                        state_nxt_s = EMPTY;
                    end else begin
                        state_nxt_s = BUSY;
                    end
                end
                FULL: begin
                    if (out_fire_s) begin
                        load_main_s = 1'b1;
                        sel_skid_s  = 1'b1;
                        state_nxt_s = BUSY;
                    end else begin
                        state_nxt_s = FULL;
                    end
                end
                default: begin
                    state_nxt_s = EMPTY;
                end
            endcase
        end
    end

    // State register with handshake flags decoded from the next state, so they are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            full_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s != FULL);
            out_valid_r <= (state_nxt_s != EMPTY);
            full_r      <= (state_nxt_s == FULL);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign full      = full_r;
    assign load_main = load_main_s;
    assign load_skid = load_skid_s;
    assign sel_skid  = sel_skid_s;

endmodule

// File: rtl/memwb_skid_stage.sv
// memwb_skid_stage: MEM->WB pipeline register with valid/ready handshake and a
// two-entry skid buffer, so WB backpressure never reaches in_ready combinationally.
// Optional feature macro: MEMWB_SKID_PERF_EN adds the CNT_W parameter and the
// stall_cnt / full_cnt saturating performance counters.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   flush                        : discard all held entries
//   in_valid / in_ready          : MEM-side handshake
//   in_mem_rd, in_alu, in_wb, in_wn : MEM-side payload
//   out_valid / out_ready        : WB-side handshake
//   out_mem_rd, out_alu, out_wb, out_wn : WB-side payload (out_wb masked to 0 when !out_valid)
//   stall_cnt, full_cnt          : (perf build) cycles stalled by WB / cycles spent FULL
module memwb_skid_stage #(
    parameter int DATA_W = memwb_pkg::DATA_W,
    parameter int CTRL_W = memwb_pkg::CTRL_W,
    parameter int RN_W   = memwb_pkg::RN_W
`ifdef MEMWB_SKID_PERF_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_mem_rd,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [CTRL_W-1:0] in_wb,
    input  logic [RN_W-1:0]   in_wn,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_mem_rd,
    output logic [DATA_W-1:0] out_alu,
    output logic [CTRL_W-1:0] out_wb,
    output logic [RN_W-1:0]   out_wn
`ifdef MEMWB_SKID_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  full_cnt
`endif
);
    import memwb_pkg::*;

    typedef struct packed {
        logic [DATA_W-1:0] mem_rd;
        logic [DATA_W-1:0] alu;
        logic [CTRL_W-1:0] wb;
        logic [RN_W-1:0]   wn;
    } payload_t;

    localparam int PAYLOAD_W = $bits(payload_t);

    payload_t in_pl_s;
    payload_t main_r;
    payload_t skid_r;
    logic     in_ready_s;
    logic     out_valid_s;
    logic     full_s;
    logic     load_main_s;
    logic     load_skid_s;
    logic     sel_skid_s;

    assign in_pl_s = '{mem_rd: in_mem_rd, alu: in_alu, wb: in_wb, wn: in_wn};

    memwb_skid_ctrl u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready_s),
        .out_valid (out_valid_s),
        .full      (full_s),
        .load_main (load_main_s),
        .load_skid (load_skid_s),
        .sel_skid  (sel_skid_s)
    );

    // Main payload register: drives the outputs; refills from input or from skid.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_r <= payload_t'({PAYLOAD_W{1'b0}});
        end else if (load_main_s) begin
            main_r <= sel_skid_s ? skid_r : in_pl_s;
        end else begin
            main_r <= main_r;
        end
    end

    // Skid payload register: captures the one accept made as backpressure appears.
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_r <= payload_t'({PAYLOAD_W{1'b0}});
        end else if (load_skid_s) begin
            skid_r <= in_pl_s;
        end else begin
            skid_r <= skid_r;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_s;
    assign out_mem_rd = main_r.mem_rd;
    assign out_alu    = main_r.alu;
    assign out_wn     = main_r.wn;
    // Stale payload survives a flush, so the control field (incl. WB_WE_BIT) is masked.
    assign out_wb     = out_valid_s ? main_r.wb : {CTRL_W{1'b0}};

`ifdef MEMWB_SKID_PERF_EN
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] full_cnt_r;

    // Saturating count of cycles where WB holds off a presented entry; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (out_valid_s && !out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Saturating count of cycles spent with both entries occupied; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_cnt_r <= {CNT_W{1'b0}};
        end else if (full_s && (full_cnt_r != {CNT_W{1'b1}})) begin
            full_cnt_r <= full_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            full_cnt_r <= full_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign full_cnt  = full_cnt_r;
`else
    logic unused_full_s;
    assign unused_full_s = full_s;
`endif

endmodule

// File: doc/memwb_skid_stage.md
# memwb_skid_stage

Parametrised MEM→WB pipeline stage with a valid/ready handshake and a two-entry skid buffer. It replaces the plain enable-gated MEM/WB register so that write-back backpressure does not combinationally reach the memory stage. It carries the memory read data, ALU result, write-back control and destination register number. It also adds flush and bubble masking of the write-back control.

## Interface
Parameters:
- DATA_W, 32, width of memory read data and ALU result
- CTRL_W, 2, width of write-back control field; bit 0 = register write enable
- RN_W, 5, width of destination register number
- CNT_W, 16, perf counter width (used only with MEMWB_SKID_PERF_EN)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all held entries
- in_valid  in  1  MEM stage presents an entry
- in_ready  out  1  stage can accept; driven purely from state
- in_mem_rd  in  DATA_W  memory read data
- in_alu  in  DATA_W  ALU result
- in_wb  in  CTRL_W  write-back control
- in_wn  in  RN_W  destination register
- out_valid  out  1  entry presented to WB
- out_ready  in  1  WB consumes entry
- out_mem_rd, out_alu  out  DATA_W  held payload
- out_wb  out  CTRL_W  held control; forced 0 when out_valid=0
- out_wn  out  RN_W  held destination
- stall_cnt  out  CNT_W  (PERF only) saturating count of cycles with out_valid & !out_ready
- full_cnt  out  CNT_W  (PERF only) saturating count of cycles in FULL

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Two payload registers: main, which drives the outputs, and skid.
- States (registered): EMPTY, BUSY (main valid), FULL (main and skid valid).
- in_ready = (state != FULL); out_valid = (state != EMPTY).
- EMPTY: in_fire → main<=in, BUSY.
- BUSY:
  - in_fire & out_fire → main<=in, stay BUSY.
  - in_fire only → skid<=in, FULL.
  - out_fire only → EMPTY.
  - Neither → hold.
- FULL: out_fire → main<=skid, BUSY. Otherwise hold; no input is accepted.
- Order is strictly FIFO; no entry is duplicated or dropped except by flush/rst.
- flush: next state EMPTY regardless of in_valid/out_ready. An entry presented in the same cycle is discarded (upstream flushes in step). Payload registers keep their stale contents, but out_wb reads 0 via masking.
- Priority: rst > flush > handshake.
- Payload registers load only on the transitions above; they never load otherwise.

## Timing
- Latency: 1 cycle from in_fire to out_valid when EMPTY.
- Throughput: 1 entry/cycle when out_ready is held high.
- in_ready has no combinational path from out_ready. The skid entry absorbs the one accept made in the cycle backpressure first appears.
- Reset values: state EMPTY; out_valid 0; in_ready 1 in the first cycle after rst deasserts; out_mem_rd, out_alu, out_wb, out_wn all 0; skid contents 0; counters 0.
- rst asserted mid-transfer: all entries lost, outputs 0 next edge.
- Upstream must hold in_* stable while in_valid & !in_ready.

## Configuration
- MEMWB_SKID_PERF_EN defined:
  - stall_cnt and full_cnt ports and their counters exist.
  - Counters increment per qualifying cycle, saturate at all-ones, and clear on rst only (not flush).
- Undefined: the ports and logic are absent; the datapath is otherwise identical.

## Structure
- Package memwb_pkg:
  - State enum (EMPTY/BUSY/FULL).
  - Default width localparams (DATA_W, CTRL_W, RN_W).
  - WB_WE_BIT index.
  - Packed payload struct typedef.
- One sub-module, memwb_skid_ctrl: the state machine. It produces in_ready, out_valid, load_main, load_skid and sel_skid. The top holds payload registers, masking and counters.

## Test plan
- Reset: drive rst 2 cycles with in_valid=1 → out_valid=0, out_wb=0, out_alu=0; first cycle after release in_ready=1.
- Streaming: 8 entries alu=0x10..0x17, out_ready=1 → out_alu 0x10..0x17 on consecutive cycles starting 1 cycle after first in_fire; in_ready stays 1.
- Backpressure: stream alu=0xA,0xB,0xC; drop out_ready after 0xA appears → 0xB lands in skid, in_ready=0 next cycle, 0xC held upstream. Raise out_ready → order 0xA,0xB,0xC, no loss.
- Flush in FULL with in_valid=1 (alu=0xD) → next cycle out_valid=0, out_wb=0, in_ready=1; 0xD never appears.
- Simultaneous in_fire & out_fire in BUSY → state stays BUSY, out_alu updates to the new value, skid unused.
- PERF: hold out_valid=1 and out_ready=0 for 5 cycles with CNT_W=2 → stall_cnt saturates at 3; flush leaves it at 3; rst clears it.
